// File: rtl/dw02_mult_pipe_hs.sv
// dw02_mult_pipe_hs: parametrised pipelined multiplier with valid/ready handshake, bubble collapsing and sideband tag
module dw02_mult_pipe_hs #(
   parameter int A_width    = 8,
   parameter int B_width    = 8,
   parameter int NUM_STAGES = 6,
   parameter int TAG_width  = 4
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         IN_VALID,
   output logic                         IN_READY,
   input  logic [A_width-1:0]           A,
   input  logic [B_width-1:0]           B,
   input  logic                         TC,
   input  logic [TAG_width-1:0]         IN_TAG,
   output logic                         OUT_VALID,
   input  logic                         OUT_READY,
   output logic [A_width+B_width-1:0]   PRODUCT,
   output logic [TAG_width-1:0]         OUT_TAG
);
   localparam int W = A_width + B_width;
   logic [NUM_STAGES-1:0] v, ld, sv;
   logic [W-1:0]          p  [NUM_STAGES];
   logic [W-1:0]          sp [NUM_STAGES];
   logic [TAG_width-1:0]  t  [NUM_STAGES];
   logic [TAG_width-1:0]  st [NUM_STAGES];
   logic [W-1:0]          a_x, b_x, prod;
   // Extending both operands to the full result width makes one modular multiply exact for either mode
   always_comb begin
      a_x  = {{B_width{TC & A[A_width-1]}}, A};
      b_x  = {{A_width{TC & B[B_width-1]}}, B};
      prod = a_x * b_x;
   end
   always_comb begin
      sv    = '0;
      sv[0] = IN_VALID;
      sp[0] = prod;
      st[0] = IN_TAG;
      for (int i = 1; i < NUM_STAGES; i++) begin
         sv[i] = v[i-1];
         sp[i] = p[i-1];
         st[i] = t[i-1];
      end
   end
   // A stage may load whenever any stage from it to the output holds a bubble, or the output drains
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_ld
      assign ld[k] = OUT_READY | ~&v[NUM_STAGES-1:k];
   end
   always_ff @(posedge CLK)
      if (RST) begin
         v <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            p[i] <= '0;
            t[i] <= '0;
         end
      end else
         for (int i = 0; i < NUM_STAGES; i++)
            if (ld[i]) begin
               v[i] <= sv[i];
               if (sv[i]) begin
                  p[i] <= sp[i];
                  t[i] <= st[i];
               end
            end
   assign IN_READY  = ld[0] & ~RST;
   assign OUT_VALID = v[NUM_STAGES-1];
   assign PRODUCT   = p[NUM_STAGES-1];
   assign OUT_TAG   = t[NUM_STAGES-1];
endmodule

// File: tb/tb_dw02_mult_pipe_hs.sv
// tb_dw02_mult_pipe_hs: directed and random scoreboard bench for dw02_mult_pipe_hs
module tb_dw02_mult_pipe_hs;
   logic clk = 0;
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0, n_dlv = 0, sweep_done = 0;
   logic rst = 1, in_valid = 0, out_ready = 0, tc = 0, in_ready, out_valid;
   logic [7:0]  a = 0, b = 0;
   logic [3:0]  in_tag = 0, out_tag;
   logic [15:0] product;
   logic [19:0] q [$];

   dw02_mult_pipe_hs u_dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b), .TC(tc),
      .IN_TAG(in_tag), .OUT_VALID(out_valid), .OUT_READY(out_ready), .PRODUCT(product), .OUT_TAG(out_tag)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m8(input logic [7:0] x, input logic [7:0] y, input logic s);
      return s ? 16'(16'($signed(x)) * 16'($signed(y))) : 16'(x) * 16'(y);
   endfunction

   function automatic logic [27:0] m16(input logic [15:0] x, input logic [11:0] y, input logic s);
      return s ? 28'(28'($signed(x)) * 28'($signed(y))) : 28'(x) * 28'(y);
   endfunction

   task automatic tick();
      #1;
      if (out_valid && out_ready) begin
         chk("sb_nonempty", 64'(q.size() != 0), 1);
         if (q.size() != 0) chk("sb_data", {product, out_tag}, q.pop_front());
         n_dlv++;
      end
      if (in_valid && in_ready) q.push_back({m8(a, b, tc), in_tag});
      @(negedge clk);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int NS = g == 0 ? 1 : g == 1 ? 3 : 8;
      logic srst = 1, sv = 0, sr = 0, stc = 0, sir, sov, hold = 0;
      logic [15:0] sa = 0;
      logic [11:0] sb = 0;
      logic [7:0]  stg = 0, sot;
      logic [27:0] sp;
      logic [35:0] held = 0;
      logic [35:0] sq [$];
      int lat;
      dw02_mult_pipe_hs #(.A_width(16), .B_width(12), .NUM_STAGES(NS), .TAG_width(8)) u_sw (
         .CLK(clk), .RST(srst), .IN_VALID(sv), .IN_READY(sir), .A(sa), .B(sb), .TC(stc),
         .IN_TAG(stg), .OUT_VALID(sov), .OUT_READY(sr), .PRODUCT(sp), .OUT_TAG(sot)
      );
      initial begin
         lat = 0;
         repeat (2) @(negedge clk);
         srst = 0; sr = 1; sv = 1; sa = 16'hFFFF; sb = 12'h7FF; stc = 1; stg = 8'hA5;
         #1 chk("sw_ready", sir, 1);
         @(negedge clk);
         sv = 0;
         while (!sov && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         chk("sw_latency", lat, NS - 1);
         chk("sw_lat_prod", sp, 28'hFFFF801);
         chk("sw_lat_tag", sot, 8'hA5);
         for (int i = 0; i < 4500; i++) begin
            @(negedge clk);
            if (hold) chk("sw_hold", {sov, sp, sot}, {1'b1, held});
            sv  = $urandom_range(0, 3) != 0;
            sr  = $urandom_range(0, 3) != 0;
            sa  = 16'($urandom);
            sb  = 12'($urandom);
            stc = 1'($urandom);
            stg = 8'($urandom);
            #1;
            if (sov && sr) begin
               chk("sw_nonempty", 64'(sq.size() != 0), 1);
               if (sq.size() != 0) chk("sw_data", {sp, sot}, sq.pop_front());
            end
            if (sv && sir) sq.push_back({m16(sa, sb, stc), stg});
            hold = sov && !sr;
            held = {sp, sot};
         end
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sv = 0;
            sr = 1;
            #1;
            if (sov && sq.size() != 0) chk("sw_drain", {sp, sot}, sq.pop_front());
         end
         chk("sw_drained", sq.size(), 0);
         sweep_done++;
      end
   end

   initial begin
      int n_acc, dlv0, stale;
      @(negedge clk);
      tick();
      tick();
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_product", product, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 0;
      #1 chk("ready_after_rst", in_ready, 1);
      // basic unsigned op and no-stall latency
      out_ready = 1; in_valid = 1; a = 8'd255; b = 8'd255; tc = 0; in_tag = 4'd3;
      tick();
      in_valid = 0;
      for (int k = 0; k <= 5; k++) begin
         #1 chk("basic_lat", out_valid, 64'(k == 5));
         if (k < 5) tick();
      end
      chk("basic_prod", product, 16'hFE01);
      chk("basic_tag", out_tag, 4'd3);
      tick();
      // signed/unsigned back-to-back
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; a = 8'h80; b = i == 0 ? 8'hFF : 8'h7F; tc = i < 2; in_tag = 4'(i + 4);
         tick();
      end
      in_valid = 0;
      repeat (3) tick();
      #1 chk("signed_0", product, 16'h0080);
      tick();
      chk("signed_1", product, 16'hC080);
      tick();
      chk("signed_2", product, 16'h3F80);
      repeat (3) tick();
      // backpressure: pipe fills to depth, then drains in order
      out_ready = 0; in_valid = 1; tc = 0; n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         in_tag = 4'(n_acc); a = 8'(n_acc * 17 + 3); b = 8'(200 - n_acc * 7);
         #1;
         if (in_ready) n_acc++;
         tick();
      end
      chk("bp_accepted", n_acc, 6);
      #1 chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_tag", out_tag, 0);
      chk("bp_hold_prod", product, 16'h0258);
      out_ready = 1; dlv0 = n_dlv;
      for (int i = 0; i < 10; i++) begin
         in_valid = n_acc < 10; in_tag = 4'(n_acc); a = 8'(n_acc * 17 + 3); b = 8'(200 - n_acc * 7);
         #1 chk("bp_stream_valid", out_valid, 1);
         if (in_valid && in_ready) n_acc++;
         tick();
      end
      chk("bp_all_in", n_acc, 10);
      chk("bp_delivered", n_dlv - dlv0, 10);
      chk("bp_empty", q.size(), 0);
      // full pipe: one in and one out in the same cycle
      out_ready = 0; in_valid = 1;
      for (int i = 0; i < 10; i++) begin
         in_tag = 4'(i); a = 8'(i + 9); b = 8'(i * 3 + 1);
         #1;
         if (!in_ready) break;
         tick();
      end
      chk("full_occupancy", q.size(), 6);
      in_tag = 4'd10; a = 8'hC3; b = 8'h5A; tc = 1; out_ready = 1;
      #1 chk("full_in_ready", in_ready, 1);
      tick();
      out_ready = 0;
      #1 chk("full_ready_drop", in_ready, 0);
      chk("full_still_full", q.size(), 6);
      out_ready = 1; in_valid = 0;
      repeat (8) tick();
      chk("full_drained", q.size(), 0);
      // reset with four operations in flight
      tc = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_tag = 4'(i + 1); a = 8'(i + 40); b = 8'(i + 50);
         tick();
      end
      in_valid = 0; rst = 1;
      tick();
      rst = 0;
      q.delete();
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_product", product, 0);
      chk("mid_rst_ready", in_ready, 1);
      stale = 0;
      repeat (10) begin
         #1 if (out_valid) stale++;
         tick();
      end
      chk("mid_rst_stale", stale, 0);
      for (int i = 0; i < 100000 && sweep_done < 3; i++) @(negedge clk);
      chk("sweep_done", sweep_done, 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
